// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline constants and the fetch-entry type
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/pq_storage.sv
// rtl/pq_storage.sv - prefetch queue entry array, one write port, one async read port
module pq_storage
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3 * XLEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Contents are never reset; the owner masks reads of invalid slots.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - fetch-to-decode instruction queue replacing the IF/ID register
module instr_prefetch_queue #(
  parameter int                            DEPTH     = 4,
  parameter int                            XLEN      = riscv_pkg::XLEN,
  parameter logic [riscv_pkg::XLEN-1:0]    NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ValidF,
  input  logic [XLEN-1:0]            InstrF,
  input  logic [XLEN-1:0]            PCF,
  input  logic [XLEN-1:0]            PCPlus4F,
  output logic                       ReadyF,
  input  logic                       FlushE,
  input  logic                       StallD,
  output logic                       ValidD,
  output logic [XLEN-1:0]            InstrD,
  output logic [XLEN-1:0]            PCD,
  output logic [XLEN-1:0]            PCPlus4D,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 3 * XLEN;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_rdata;

  // Ready/valid come from registered occupancy only, so no stall-to-fetch path.
  assign ReadyF = (r_cnt != CW'(DEPTH));
  assign ValidD = (r_cnt != '0);
  assign w_push = ValidF & ReadyF & ~FlushE;
  assign w_pop  = ValidD & ~StallD & ~FlushE;

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  pq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (PW)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({InstrF, PCF, PCPlus4F}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Empty queue shows a NOP bubble so hazard logic sees rd = x0, never stale storage.
  assign InstrD   = ValidD ? w_rdata[3*XLEN-1:2*XLEN] : NOP_INSTR;
  assign PCD      = ValidD ? w_rdata[2*XLEN-1:XLEN]   : '0;
  assign PCPlus4D = ValidD ? w_rdata[XLEN-1:0]        : '0;
  assign Count    = r_cnt;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ReadyF;
  logic        FlushE;
  logic        StallD;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [2:0]  Count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t q[$];

  instr_prefetch_queue dut (
    .clk      (clk),
    .rst      (rst),
    .ValidF   (ValidF),
    .InstrF   (InstrF),
    .PCF      (PCF),
    .PCPlus4F (PCPlus4F),
    .ReadyF   (ReadyF),
    .FlushE   (FlushE),
    .StallD   (StallD),
    .ValidD   (ValidD),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .Count    (Count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[19:0], 12'h093};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: a plain FIFO of entries with capacity DEPTH.
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst || FlushE) begin
      q.delete();
    end else begin
      do_pop  = (q.size() != 0) && !StallD;
      do_push = ValidF && (q.size() < DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{InstrF, PCF, PCPlus4F});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_count", {29'd0, Count}, 32'(q.size()));
      check("cmp_validd", {31'd0, ValidD}, {31'd0, q.size() != 0});
      check("cmp_readyf", {31'd0, ReadyF}, {31'd0, q.size() < DEPTH});
      check("cmp_instrd", InstrD, (q.size() != 0) ? q[0].instr : NOP);
      check("cmp_pcd", PCD, (q.size() != 0) ? q[0].pc : 32'd0);
      check("cmp_pc4d", PCPlus4D, (q.size() != 0) ? q[0].pc4 : 32'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    ValidF   = v;
    PCF      = pc;
    InstrF   = instr_of(pc);
    PCPlus4F = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1; FlushE = 1'b0; StallD = 1'b0;
    offer(1'b1, 32'h0000_0800);

    // 1 reset with ValidF held high
    tick; tick;
    offer(1'b0, 32'd0);
    check("rst_count", {29'd0, Count}, 32'd0);
    check("rst_validd", {31'd0, ValidD}, 32'd0);
    check("rst_instrd", InstrD, 32'h00000013);
    check("rst_readyf", {31'd0, ReadyF}, 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;

    // 2 fill under stall, fifth offer ignored, then drain
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'(4 * i));
      tick;
    end
    offer(1'b1, 32'd16);
    tick;
    check("fill_count", {29'd0, Count}, 32'd4);
    check("fill_readyf", {31'd0, ReadyF}, 32'd0);
    check("fill_head", PCD, 32'd0);
    offer(1'b0, 32'd0);
    StallD = 1'b0;
    tick; check("drain_pc1", PCD, 32'd4);
    tick; check("drain_pc2", PCD, 32'd8);
    tick; check("drain_pc3", PCD, 32'd12);
    check("drain_pc4_p4", PCPlus4D, 32'd16);
    tick; check("drain_empty", {31'd0, ValidD}, 32'd0);

    // 3 streaming across several pointer wraps
    for (int k = 0; k <= 16; k++) begin
      offer(1'b1, 32'(4 * k));
      tick;
      check("stream_count", {29'd0, Count}, 32'd1);
      check("stream_pcd", PCD, 32'(4 * k));
      check("stream_instr", InstrD, instr_of(32'(4 * k)));
    end
    offer(1'b0, 32'd0);
    tick;
    check("stream_end_instr", InstrD, NOP);

    // 4 flush discards queued entries and the same-cycle push
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h10 + 32'(4 * i));
      tick;
    end
    check("pre_flush_count", {29'd0, Count}, 32'd3);
    offer(1'b1, 32'h100);
    FlushE = 1'b1;
    tick;
    FlushE = 1'b0;
    check("flush_count", {29'd0, Count}, 32'd0);
    check("flush_instrd", InstrD, 32'h00000013);
    StallD = 1'b0;
    offer(1'b1, 32'h200);
    tick;
    check("redirect_pcd", PCD, 32'h200);
    offer(1'b0, 32'd0);
    tick;
    check("redirect_done", {31'd0, ValidD}, 32'd0);

    // 5 full queue pops only; push+pop keeps count
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h300 + 32'(4 * i));
      tick;
    end
    StallD = 1'b0;
    offer(1'b1, 32'h400);
    tick;
    check("full_pop_count", {29'd0, Count}, 32'd3);
    check("full_pop_pcd", PCD, 32'h304);
    offer(1'b0, 32'd0);
    tick;
    check("two_count", {29'd0, Count}, 32'd2);
    offer(1'b1, 32'h500);
    tick;
    check("pushpop_count", {29'd0, Count}, 32'd2);
    check("pushpop_pcd", PCD, 32'h30c);
    offer(1'b0, 32'd0);
    tick;
    check("tail_pcd", PCD, 32'h500);
    tick;

    // 6 reset wins over flush and stall mid-operation
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h600 + 32'(4 * i));
      tick;
    end
    offer(1'b0, 32'd0);
    FlushE = 1'b1;
    rst = 1'b1;
    tick;
    check("mid_rst_count", {29'd0, Count}, 32'd0);
    check("mid_rst_readyf", {31'd0, ReadyF}, 32'd1);
    check("mid_rst_pcd", PCD, 32'd0);
    check("mid_rst_pc4d", PCPlus4D, 32'd0);
    rst = 1'b0;
    FlushE = 1'b0;
    StallD = 1'b0;
    tick;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
